bcd_scan_ctrl: RTL and testbench
================================

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clocks per digit slot (legal range 2..65535).
REQ-002 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port EN  input  1  scan enable; 0 blanks the display.
REQ-005 SHALL have port LZB  input  1  leading-zero blanking enable.
REQ-006 SHALL have port LOAD  input  1  one-cycle request to load DIN.
REQ-007 SHALL have port DIN  input  16  four BCD digits; DIN[3:0] is digit 0 (rightmost).
REQ-008 SHALL have port READY  output  1  high when LOAD will be accepted.
REQ-009 SHALL have port ERR  output  1  one-cycle pulse on a rejected LOAD.
REQ-010 SHALL have port NUM  output  4  BCD code for the 7-segment decoder; 4'hF means blank.
REQ-011 SHALL have port DIGIT_EN  output  4  one-hot digit enable, active-high; bit i drives digit i.
REQ-012 SHALL have port FRAME  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-013 SHALL implement states OFF and SCAN; OFF->SCAN when EN=1; SCAN->OFF on the cycle after EN=0.
REQ-014 In OFF, SHALL drive DIGIT_EN=0000 and NUM=4'hF, and SHALL hold the slot counter and digit index at 0.
REQ-015 In SCAN, SHALL count the slot counter 0..DIV-1; at DIV-1 it SHALL return to 0 and advance the index 0->1->2->3->0.
REQ-016 SHALL drive NUM from the displayed digit at the current index for the whole slot, or 4'hF if that digit is blanked.
REQ-017 SHALL drive DIGIT_EN=0000 at slot count 0 (anti-ghosting gap).
REQ-018 SHALL drive DIGIT_EN one-hot at the index for counts 1..DIV-1, except DIGIT_EN=0000 for a blanked digit.
REQ-019 SHALL pulse FRAME=1 for the single cycle in which the index changes from 3 to 0.
REQ-020 With LZB=1, SHALL blank digit i (i=3..1) iff digit i and all higher digits are 0; digit 0 is never blanked; with LZB=0 nothing is blanked.
REQ-021 SHALL keep a 16-bit shadow register and a pending flag; READY = not pending.
REQ-022 On LOAD=1 with READY=1 and every DIN nibble <=9, in SCAN: SHALL set shadow<=DIN and pending<=1, so READY=0 from the next cycle.
REQ-023 SHALL copy a pending shadow into the displayed digits on the FRAME cycle, clear pending, and return READY=1 on the following cycle.
REQ-024 On LOAD in OFF with a valid DIN, SHALL write the displayed digits directly on the next edge; pending stays 0 and READY stays 1.
REQ-025 SHALL ignore LOAD when READY=0, with no ERR and no state change.
REQ-026 On LOAD with READY=1 and any DIN nibble >9, SHALL accept nothing and pulse ERR=1 for one cycle.
REQ-027 On LOAD accepted in the same cycle as FRAME, SHALL apply it at the next FRAME, not the current one.
REQ-028 On EN=0 with an update pending, SHALL apply the shadow on entry to OFF and clear pending.
REQ-029 SHALL register all outputs; the slot counter is ceil(log2(DIV)) bits and never exceeds DIV-1.

Reset
REQ-030 While RST_N=0, SHALL force: state OFF, counter 0, index 0, displayed digits 0000, shadow 0, pending 0, READY=1, ERR=0, FRAME=0, NUM=4'hF, DIGIT_EN=0000.
REQ-031 On RST_N asserted mid-scan or mid-pending, SHALL discard the pending data and show no partial frame; scanning resumes from digit 0 at count 0.

Verification (DIV=4)
REQ-032 Scan: reset, LOAD DIN=16'h1234 in OFF, then EN=1 -> per slot NUM 4,3,2,1 with DIGIT_EN 0000 for 1 clock then 0001/0010/0100/1000 for 3 clocks; FRAME every 16 clocks.
REQ-033 Tear-free update: during SCAN at index 1, LOAD 16'h5678 -> READY=0 next cycle; digits unchanged until FRAME; next frame shows 8,7,6,5; READY=1 one cycle after FRAME.
REQ-034 Rejection: LOAD 16'h12A4 -> ERR pulse, READY stays 1, display unchanged; a second LOAD while READY=0 is ignored.
REQ-035 Blanking: LZB=1, digits 16'h0050 -> digits 3 and 2 get NUM=F and DIGIT_EN=0000; digit 1 shows 5, digit 0 shows 0; 16'h0000 shows digit 0 only.
REQ-036 Boundaries: LOAD coincident with FRAME is applied one frame later; EN=0 mid-slot -> DIGIT_EN=0000 next cycle; async RST_N pulse mid-pending -> all REQ-030 values, pending data lost.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// Purpose: four-digit multiplexed BCD display scanner with tear-free shadow load and leading-zero blanking.
// Latency: all outputs are registered and describe the same cycle as the slot counter/index; a load lands at the next frame wrap (or on the next edge when the scan is off).
// Backpressure: READY drops while an update is pending; a LOAD seen with READY low is dropped silently.
//
// Ports:
//   CLK, RST_N       clock (rising edge) and asynchronous active-low reset
//   EN               scan enable; low blanks the display
//   LZB              leading-zero blanking enable
//   LOAD, DIN        one-cycle load request with four BCD nibbles (DIN[3:0] = digit 0)
//   READY, ERR       load handshake: accept-able / one-cycle reject pulse for non-BCD data
//   NUM, DIGIT_EN    digit code (4'hF = blank) and one-hot digit strobe
//   FRAME            one-cycle pulse in the slot whose end wraps the index 3 -> 0
module bcd_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic        LZB,
    input  logic        LOAD,
    input  logic [15:0] DIN,
    output logic        READY,
    output logic        ERR,
    output logic [3:0]  NUM,
    output logic [3:0]  DIGIT_EN,
    output logic        FRAME
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic {
        S_OFF  = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pend_q, pend_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          frame_q, frame_d;
    logic [3:0]    num_q, num_d;
    logic [3:0]    den_q, den_d;

    logic          din_ok;
    logic          load_acc;
    logic          wrap;
    logic [3:0]    blk;
    logic [3:0]    dsel;

    // Every nibble must be a legal BCD digit (0..9).
    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;

        din_ok   = bcd_ok(DIN);
        load_acc = LOAD && !pend_q && din_ok;
        err_d    = LOAD && !pend_q && !din_ok;
        wrap     = (state_q == S_SCAN) && EN && (cnt_q == CNT_MAX) && (idx_q == 2'd3);

        if (state_q == S_OFF) begin
            cnt_d = '0;
            idx_d = 2'd0;
            // Nothing is on screen, so a load can go straight to the digits.
            if (load_acc) disp_d = DIN;
            if (EN) state_d = S_SCAN;
        end else if (!EN) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = 2'd0;
            // Leaving the scan: no frame to tear, so flush any update now.
            if (load_acc) begin
                disp_d = DIN;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // Copy uses the shadow as it stood before this edge, so a load
            // accepted in the FRAME cycle waits for the following wrap.
            if (wrap && pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
            if (load_acc) begin
                shadow_d = DIN;
                pend_d   = 1'b1;
            end
        end

        // Blank a digit only if it and everything to its left is zero.
        blk[3] = LZB && (disp_d[15:12] == 4'd0);
        blk[2] = blk[3] && (disp_d[11:8] == 4'd0);
        blk[1] = blk[2] && (disp_d[7:4] == 4'd0);
        blk[0] = 1'b0;

        case (idx_d)
            2'd0:    dsel = disp_d[3:0];
            2'd1:    dsel = disp_d[7:4];
            2'd2:    dsel = disp_d[11:8];
            default: dsel = disp_d[15:12];
        endcase

        // Outputs are computed from the next state so the registered
        // outputs line up with the registered counter and index.
        if (state_d == S_OFF) begin
            num_d = 4'hF;
            den_d = 4'b0000;
        end else begin
            num_d = blk[idx_d] ? 4'hF : dsel;
            // Count 0 of each slot is a dark gap to avoid ghosting.
            den_d = ((cnt_d == '0) || blk[idx_d]) ? 4'b0000 : (4'b0001 << idx_d);
        end
        frame_d = (state_d == S_SCAN) && (cnt_d == CNT_MAX) && (idx_d == 2'd3);
        ready_d = !pend_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            disp_q   <= 16'h0000;
            shadow_q <= 16'h0000;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            frame_q  <= 1'b0;
            num_q    <= 4'hF;
            den_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
            num_q    <= num_d;
            den_q    <= den_d;
        end
    end

    assign READY    = ready_q;
    assign ERR      = err_q;
    assign NUM      = num_q;
    assign DIGIT_EN = den_q;
    assign FRAME    = frame_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Purpose: directed scoreboard bench for bcd_scan_ctrl with DIV=4 (16 clocks per frame).
// Latency: expected values are queued before each clock edge and popped 1 time unit after it.
// Backpressure: exercises READY low (ignored loads), rejection, frame-coincident loads and resets.
module tb_bcd_scan_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        EN;
    logic        LZB;
    logic        LOAD;
    logic [15:0] DIN;
    logic        READY;
    logic        ERR;
    logic [3:0]  NUM;
    logic [3:0]  DIGIT_EN;
    logic        FRAME;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] den;
        logic       frame;
        logic       ready;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pos    = 0;   // position within a 16-clock frame of the next observed cycle

    bcd_scan_ctrl #(.DIV(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .LZB      (LZB),
        .LOAD     (LOAD),
        .DIN      (DIN),
        .READY    (READY),
        .ERR      (ERR),
        .NUM      (NUM),
        .DIGIT_EN (DIGIT_EN),
        .FRAME    (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Expected outputs while scanning: slot = p/4, count = p%4.
    function automatic exp_t scan_exp(input logic [15:0] dig, input logic lzb,
                                      input int p, input logic rdy);
        exp_t        e;
        int          idx;
        int          cnt;
        logic [15:0] sh;
        logic        blank;
        idx   = p / 4;
        cnt   = p % 4;
        sh    = dig >> (4 * idx);
        blank = lzb && (idx != 0) && (sh == 16'h0000);
        e.num   = blank ? 4'hF : sh[3:0];
        e.den   = (blank || cnt == 0) ? 4'b0000 : 4'(1 << idx);
        e.frame = (p == 15);
        e.ready = rdy;
        e.err   = 1'b0;
        return e;
    endfunction

    function automatic exp_t off_exp(input logic rdy);
        exp_t e;
        e.num   = 4'hF;
        e.den   = 4'b0000;
        e.frame = 1'b0;
        e.ready = rdy;
        e.err   = 1'b0;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        checks++;
        assert (NUM === e.num) else begin
            errors++;
            $error("FAIL %s NUM got %h want %h", tag, NUM, e.num);
        end
        checks++;
        assert (DIGIT_EN === e.den) else begin
            errors++;
            $error("FAIL %s DIGIT_EN got %b want %b", tag, DIGIT_EN, e.den);
        end
        checks++;
        assert (FRAME === e.frame) else begin
            errors++;
            $error("FAIL %s FRAME got %b want %b", tag, FRAME, e.frame);
        end
        checks++;
        assert (READY === e.ready) else begin
            errors++;
            $error("FAIL %s READY got %b want %b", tag, READY, e.ready);
        end
        checks++;
        assert (ERR === e.err) else begin
            errors++;
            $error("FAIL %s ERR got %b want %b", tag, ERR, e.err);
        end
    endtask

    // Push the expectation for the cycle after the coming edge, then pop and check it.
    task automatic tick(input exp_t e, input string tag);
        exp_t got;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            compare(got, tag);
        end
    endtask

    task automatic scan_tick(input logic [15:0] dig, input logic lzb,
                             input logic rdy, input logic err);
        exp_t e;
        e     = scan_exp(dig, lzb, pos, rdy);
        e.err = err;
        tick(e, $sformatf("scan d%h p%0d", dig, pos));
        pos = (pos + 1) % 16;
    endtask

    task automatic run_scan(input int n, input logic [15:0] dig, input logic lzb,
                            input logic rdy);
        for (int i = 0; i < n; i++) scan_tick(dig, lzb, rdy, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0;
        EN    = 1'b0;
        LZB   = 1'b0;
        LOAD  = 1'b0;
        DIN   = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        compare(off_exp(1'b1), "reset");
        RST_N = 1'b1;

        // Direct load while off, then scan 1234 for two frames.
        LOAD = 1'b1; DIN = 16'h1234;
        tick(off_exp(1'b1), "off_load");
        LOAD = 1'b0;
        tick(off_exp(1'b1), "off_idle");
        EN  = 1'b1;
        pos = 0;
        run_scan(32, 16'h1234, 1'b0, 1'b1);

        // Tear-free update issued during slot 1.
        run_scan(5, 16'h1234, 1'b0, 1'b1);
        LOAD = 1'b1; DIN = 16'h5678;
        scan_tick(16'h1234, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(10, 16'h1234, 1'b0, 1'b0);
        run_scan(16, 16'h5678, 1'b0, 1'b1);

        // Rejected non-BCD load, then loads ignored while pending.
        LOAD = 1'b1; DIN = 16'h12A4;
        scan_tick(16'h5678, 1'b0, 1'b1, 1'b1);
        LOAD = 1'b0;
        run_scan(2, 16'h5678, 1'b0, 1'b1);
        LOAD = 1'b1; DIN = 16'h1111;
        scan_tick(16'h5678, 1'b0, 1'b0, 1'b0);
        DIN = 16'h2222;
        scan_tick(16'h5678, 1'b0, 1'b0, 1'b0);
        DIN = 16'h12A4;
        scan_tick(16'h5678, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(10, 16'h5678, 1'b0, 1'b0);
        run_scan(16, 16'h1111, 1'b0, 1'b1);

        // Leading-zero blanking.
        LZB = 1'b1;
        run_scan(1, 16'h1111, 1'b1, 1'b1);
        LOAD = 1'b1; DIN = 16'h0050;
        scan_tick(16'h1111, 1'b1, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(14, 16'h1111, 1'b1, 1'b0);
        run_scan(16, 16'h0050, 1'b1, 1'b1);
        run_scan(1, 16'h0050, 1'b1, 1'b1);
        LOAD = 1'b1; DIN = 16'h0000;
        scan_tick(16'h0050, 1'b1, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(14, 16'h0050, 1'b1, 1'b0);
        run_scan(16, 16'h0000, 1'b1, 1'b1);
        LZB = 1'b0;
        run_scan(16, 16'h0000, 1'b0, 1'b1);

        // Load in the FRAME cycle is held for one more frame.
        LOAD = 1'b1; DIN = 16'h0987;
        scan_tick(16'h0000, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(15, 16'h0000, 1'b0, 1'b0);
        run_scan(16, 16'h0987, 1'b0, 1'b1);

        // EN drop mid-slot with an update pending: dark next cycle, shadow applied.
        run_scan(2, 16'h0987, 1'b0, 1'b1);
        LOAD = 1'b1; DIN = 16'h4321;
        scan_tick(16'h0987, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0;
        EN   = 1'b0;
        tick(off_exp(1'b1), "en_off");
        tick(off_exp(1'b1), "off_hold");
        EN  = 1'b1;
        pos = 0;
        run_scan(16, 16'h4321, 1'b0, 1'b1);

        // Asynchronous reset mid-pending discards the update.
        run_scan(6, 16'h4321, 1'b0, 1'b1);
        LOAD = 1'b1; DIN = 16'h9999;
        scan_tick(16'h4321, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0;
        run_scan(3, 16'h4321, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        compare(off_exp(1'b1), "rst_async");
        @(posedge CLK);
        #1;
        compare(off_exp(1'b1), "rst_hold");
        RST_N = 1'b1;
        pos   = 0;
        run_scan(32, 16'h0000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
